// File: rtl/dm_sba_bus_arbiter.sv
// Round-robin arbiter sharing one system-bus request port among NUM_REQ requesters.
// Define DM_ARB_TIMEOUT_EN to add a response watchdog of TIMEOUT_CYCLES cycles in WAIT.
module dm_sba_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_REQ-1:0]                s_req,
  input  logic [NUM_REQ-1:0]                s_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     s_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     s_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] s_be,
  output logic [NUM_REQ-1:0]                s_gnt,
  output logic [NUM_REQ-1:0]                s_rvalid,
  output logic [DATA_WIDTH-1:0]             s_rdata,
  output logic                              s_err,
  output logic                              m_req,
  output logic                              m_we,
  output logic [ADDR_WIDTH-1:0]             m_addr,
  output logic [DATA_WIDTH-1:0]             m_wdata,
  output logic [DATA_WIDTH/8-1:0]           m_be,
  input  logic                              m_gnt,
  input  logic                              m_rvalid,
  input  logic [DATA_WIDTH-1:0]             m_rdata,
  input  logic                              m_err,
  output logic                              busy
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int CAND_W = PTR_W + 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic                 we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]      be_q, be_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 sel_found;
  logic [PTR_W-1:0]     sel_idx;
  logic [CAND_W-1:0]    cand;
  logic                 sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BE_W-1:0]      sel_be;

`ifdef DM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Search upward from the last owner + 1, wrapping, so the previous winner has lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CAND_W'(k);
      if (cand >= CAND_W'(NUM_REQ)) begin
        cand = cand - CAND_W'(NUM_REQ);
      end
      if (!sel_found && s_req[cand[PTR_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == PTR_W'(i)) begin
        sel_we    = s_we[i];
        sel_addr  = s_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_be    = s_be[i*BE_W +: BE_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    s_gnt    = '0;
    m_req    = 1'b0;
`ifdef DM_ARB_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          s_gnt   = ONE_HOT0 << sel_idx;
          owner_d = sel_idx;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          be_d    = sel_be;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        m_req = 1'b1;
        if (m_gnt) begin
          state_d = WAIT;
`ifdef DM_ARB_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      WAIT: begin
        // A real response takes priority over a watchdog expiry in the same cycle.
        if (m_rvalid) begin
          rvalid_d = ONE_HOT0 << owner_q;
          rdata_d  = m_rdata;
          err_d    = m_err;
          rr_ptr_d = owner_q;
          state_d  = IDLE;
        end
`ifdef DM_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          rvalid_d = ONE_HOT0 << owner_q;
          rdata_d  = '0;
          err_d    = 1'b1;
          rr_ptr_d = owner_q;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      rr_ptr_q <= PTR_W'(NUM_REQ - 1);
      owner_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef DM_ARB_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef DM_ARB_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign s_rvalid = rvalid_q;
  assign s_rdata  = rdata_q;
  assign s_err    = err_q;
  assign m_we     = we_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign m_be     = be_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dm_sba_bus_arbiter.sv
// Directed bench for dm_sba_bus_arbiter: a transaction-level reference model is compared
// against the DUT every cycle, plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_dm_sba_bus_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 64;
  localparam int DW      = 64;
  localparam int BW      = DW / 8;
  localparam int TMO     = 16;

  logic                 aclk    = 1'b0;
  logic                 aresetn = 1'b0;
  logic [NUM_REQ-1:0]   s_req   = '0;
  logic [NUM_REQ-1:0]   s_we    = '0;
  logic [NUM_REQ*AW-1:0] s_addr = '0;
  logic [NUM_REQ*DW-1:0] s_wdata = '0;
  logic [NUM_REQ*BW-1:0] s_be   = '0;
  logic [NUM_REQ-1:0]   s_gnt;
  logic [NUM_REQ-1:0]   s_rvalid;
  logic [DW-1:0]        s_rdata;
  logic                 s_err;
  logic                 m_req;
  logic                 m_we;
  logic [AW-1:0]        m_addr;
  logic [DW-1:0]        m_wdata;
  logic [BW-1:0]        m_be;
  logic                 m_gnt    = 1'b0;
  logic                 m_rvalid = 1'b0;
  logic [DW-1:0]        m_rdata  = '0;
  logic                 m_err    = 1'b0;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  int           gntDelay = 0;
  int           rspDelay = 2;
  logic [DW-1:0] rspData = '0;
  logic         rspErr   = 1'b0;

  logic [NUM_REQ-1:0] grantLog[$];
  logic [AW-1:0]      acceptAddrLog[$];

  bit            haveTxn   = 1'b0;
  bit            accepted  = 1'b0;
  int            owner     = 0;
  int            lastOwner = NUM_REQ - 1;
  int            waitCycles = 0;
  logic          holdWe    = 1'b0;
  logic [AW-1:0] holdAddr  = '0;
  logic [DW-1:0] holdWdata = '0;
  logic [BW-1:0] holdBe    = '0;
  logic [NUM_REQ-1:0] expRvalid = '0;
  logic [DW-1:0] expRdata  = '0;
  logic          expErr    = 1'b0;

  dm_sba_bus_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_req   (s_req),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_be    (s_be),
    .s_gnt   (s_gnt),
    .s_rvalid(s_rvalid),
    .s_rdata (s_rdata),
    .s_err   (s_err),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_be    (m_be),
    .m_gnt   (m_gnt),
    .m_rvalid(m_rvalid),
    .m_rdata (m_rdata),
    .m_err   (m_err),
    .busy    (busy)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic req, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [BW-1:0] be);
    s_req[idx]              = req;
    s_we[idx]               = we;
    s_addr[idx*AW +: AW]    = addr;
    s_wdata[idx*DW +: DW]   = wdata;
    s_be[idx*BW +: BW]      = be;
  endtask

  task automatic setReq(input int idx, input logic req);
    s_req[idx] = req;
  endtask

  task automatic waitGrants(input int n, input int limit);
    int c = 0;
    while (grantLog.size() < n && c < limit) begin
      @(posedge aclk); #1;
      c++;
    end
    if (grantLog.size() < n) checkOutput("grant_wait_timeout", 64'(grantLog.size()), 64'(n));
  endtask

  task automatic waitRvalid(input int limit);
    int c = 0;
    while (s_rvalid === '0 && c < limit) begin
      @(negedge aclk);
      c++;
    end
    if (s_rvalid === '0) checkOutput("rvalid_wait_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitIdle(input int limit);
    int c = 0;
    while (busy !== 1'b0 && c < limit) begin
      @(posedge aclk); #1;
      c++;
    end
    if (busy !== 1'b0) checkOutput("idle_wait_timeout", 64'(busy), 64'd0);
    repeat (2) begin
      @(posedge aclk); #1;
    end
  endtask

  function automatic int pickNext(input logic [NUM_REQ-1:0] req, input int last);
    for (int step = 1; step <= NUM_REQ; step++) begin
      if (req[(last + step) % NUM_REQ]) return (last + step) % NUM_REQ;
    end
    return -1;
  endfunction

  // Reference model: one outstanding transaction, owner rotates after the last one that completed.
  always @(negedge aclk) begin
    int win;
    logic [NUM_REQ-1:0] expGnt;
    logic [NUM_REQ-1:0] nextRvalid;
    if (!aresetn) begin
      haveTxn   = 1'b0;
      accepted  = 1'b0;
      lastOwner = NUM_REQ - 1;
      expRvalid = '0;
      expRdata  = '0;
      expErr    = 1'b0;
      checkOutput("rst_m_req", 64'(m_req), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_s_rvalid", 64'(s_rvalid), 64'd0);
      checkOutput("rst_s_rdata", s_rdata, 64'd0);
      checkOutput("rst_s_err", 64'(s_err), 64'd0);
    end else begin
      win    = haveTxn ? -1 : pickNext(s_req, lastOwner);
      expGnt = (win >= 0) ? (NUM_REQ'(1) << win) : '0;
      checkOutput("s_gnt", 64'(s_gnt), 64'(expGnt));
      checkOutput("s_rvalid", 64'(s_rvalid), 64'(expRvalid));
      checkOutput("s_rdata", s_rdata, expRdata);
      checkOutput("s_err", 64'(s_err), 64'(expErr));
      checkOutput("m_req", 64'(m_req), 64'(haveTxn && !accepted));
      checkOutput("busy", 64'(busy), 64'(haveTxn));
      if (haveTxn && !accepted) begin
        checkOutput("m_we", 64'(m_we), 64'(holdWe));
        checkOutput("m_addr", m_addr, holdAddr);
        checkOutput("m_wdata", m_wdata, holdWdata);
        checkOutput("m_be", 64'(m_be), 64'(holdBe));
      end
      if (s_gnt !== '0) grantLog.push_back(s_gnt);
      if (m_req && m_gnt) acceptAddrLog.push_back(m_addr);

      nextRvalid = '0;
      if (win >= 0) begin
        haveTxn   = 1'b1;
        accepted  = 1'b0;
        owner     = win;
        holdWe    = s_we[win];
        holdAddr  = s_addr[win*AW +: AW];
        holdWdata = s_wdata[win*DW +: DW];
        holdBe    = s_be[win*BW +: BW];
      end else if (haveTxn && !accepted) begin
        if (m_gnt) begin
          accepted   = 1'b1;
          waitCycles = 0;
        end
      end else if (haveTxn) begin
        if (m_rvalid) begin
          nextRvalid = NUM_REQ'(1) << owner;
          expRdata   = m_rdata;
          expErr     = m_err;
          lastOwner  = owner;
          haveTxn    = 1'b0;
        end
`ifdef DM_ARB_TIMEOUT_EN
        else begin
          waitCycles++;
          if (waitCycles == TMO) begin
            nextRvalid = NUM_REQ'(1) << owner;
            expRdata   = '0;
            expErr     = 1'b1;
            lastOwner  = owner;
            haveTxn    = 1'b0;
          end
        end
`endif
      end
      expRvalid = nextRvalid;
    end
  end

  // Downstream slave: accepts after gntDelay ISSUE cycles, responds rspDelay cycles after accept (0 = never).
  initial begin
    int issueWait = 0;
    int rspCnt    = 0;
    forever begin
      @(posedge aclk); #2;
      if (!aresetn) begin
        issueWait = 0;
        rspCnt    = 0;
        m_gnt     = 1'b0;
        m_rvalid  = 1'b0;
      end else begin
        m_rvalid = 1'b0;
        if (m_gnt) begin
          m_gnt     = 1'b0;
          issueWait = 0;
          rspCnt    = rspDelay;
        end else if (m_req) begin
          if (issueWait >= gntDelay) m_gnt = 1'b1;
          else issueWait++;
        end
        if (rspCnt > 0) begin
          rspCnt--;
          if (rspCnt == 0) begin
            m_rvalid = 1'b1;
            m_rdata  = rspData;
            m_err    = rspErr;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the bench finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int busyHigh;

    repeat (3) @(posedge aclk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_m_req", 64'(m_req), 64'd0);
    checkOutput("reset_s_gnt", 64'(s_gnt), 64'd0);
    checkOutput("reset_s_rvalid", 64'(s_rvalid), 64'd0);
    aresetn = 1'b1;

    $display("[TB] rotation with both requesters active");
    applyStimulus(0, 1'b1, 1'b0, 64'h1000, 64'h11, 8'hFF);
    applyStimulus(1, 1'b1, 1'b0, 64'h2000, 64'h22, 8'h0F);
    waitGrants(3, 60);
    setReq(0, 1'b0);
    setReq(1, 1'b0);
    waitIdle(40);
    checkOutput("rot_grant0", 64'(grantLog[0]), 64'h1);
    checkOutput("rot_grant1", 64'(grantLog[1]), 64'h2);
    checkOutput("rot_grant2", 64'(grantLog[2]), 64'h1);
    checkOutput("rot_addr0", acceptAddrLog[0], 64'h1000);
    checkOutput("rot_addr1", acceptAddrLog[1], 64'h2000);

    $display("[TB] requester 1 read response");
    rspData = 64'hDEADBEEF_CAFEF00D;
    rspErr  = 1'b0;
    base    = grantLog.size();
    applyStimulus(1, 1'b1, 1'b0, 64'h8000_0000, 64'h0, 8'hFF);
    waitGrants(base + 1, 20);
    setReq(1, 1'b0);
    waitRvalid(20);
    checkOutput("read_s_rvalid", 64'(s_rvalid), 64'h2);
    checkOutput("read_s_rdata", s_rdata, 64'hDEADBEEF_CAFEF00D);
    checkOutput("read_s_err", 64'(s_err), 64'd0);
    waitIdle(20);

    $display("[TB] held request while downstream stalls");
    gntDelay = 5;
    base     = grantLog.size();
    applyStimulus(0, 1'b1, 1'b1, 64'h3000, 64'hA5A5, 8'h3C);
    waitGrants(base + 1, 20);
    setReq(0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      s_addr[0 +: AW] = 64'h9000 + 64'(k);
      #1;
      checkOutput("stall_m_req", 64'(m_req), 64'd1);
      checkOutput("stall_m_addr", m_addr, 64'h3000);
      @(posedge aclk); #1;
    end
    waitIdle(40);
    gntDelay = 0;

    $display("[TB] reset during WAIT");
    rspDelay = 0;
    base     = grantLog.size();
    applyStimulus(1, 1'b1, 1'b0, 64'h4000, 64'h0, 8'hFF);
    waitGrants(base + 1, 20);
    setReq(1, 1'b0);
    repeat (3) begin
      @(posedge aclk); #1;
    end
    aresetn = 1'b0;
    #1;
    checkOutput("abort_m_req", 64'(m_req), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_s_rvalid", 64'(s_rvalid), 64'd0);
    repeat (2) begin
      @(posedge aclk); #1;
    end
    aresetn = 1'b1;
    @(posedge aclk); #3;
    m_rdata  = 64'h5555_AAAA;
    m_rvalid = 1'b1;
    repeat (2) begin
      @(posedge aclk); #1;
    end
    checkOutput("stale_s_rvalid", 64'(s_rvalid), 64'd0);
    rspDelay = 2;
    base     = grantLog.size();
    applyStimulus(0, 1'b1, 1'b0, 64'h5000, 64'h0, 8'hFF);
    applyStimulus(1, 1'b1, 1'b0, 64'h6000, 64'h0, 8'hFF);
    waitGrants(base + 1, 10);
    setReq(0, 1'b0);
    setReq(1, 1'b0);
    checkOutput("post_reset_first_grant", 64'(grantLog[base]), 64'h1);
    waitIdle(20);

`ifdef DM_ARB_TIMEOUT_EN
    $display("[TB] response watchdog");
    rspDelay = 0;
    base     = grantLog.size();
    applyStimulus(0, 1'b1, 1'b0, 64'h7000, 64'h0, 8'hFF);
    waitGrants(base + 1, 20);
    setReq(0, 1'b0);
    waitRvalid(60);
    checkOutput("tmo_s_rvalid", 64'(s_rvalid), 64'h1);
    checkOutput("tmo_s_err", 64'(s_err), 64'd1);
    checkOutput("tmo_s_rdata", s_rdata, 64'd0);
    @(posedge aclk); #1;
    checkOutput("tmo_busy", 64'(busy), 64'd0);
    rspDelay = 2;
`else
    $display("[TB] missing response without watchdog");
    rspDelay = 0;
    base     = grantLog.size();
    applyStimulus(0, 1'b1, 1'b0, 64'h7000, 64'h0, 8'hFF);
    waitGrants(base + 1, 20);
    setReq(0, 1'b0);
    busyHigh = 0;
    repeat (100) begin
      @(posedge aclk); #1;
      if (busy === 1'b1) busyHigh++;
    end
    checkOutput("no_tmo_busy_cycles", 64'(busyHigh), 64'd100);
    aresetn = 1'b0;
    repeat (2) begin
      @(posedge aclk); #1;
    end
    aresetn  = 1'b1;
    rspDelay = 2;
    @(posedge aclk); #1;
`endif

    $display("[TB] error response then rotation");
    rspData = 64'h0BAD;
    rspErr  = 1'b1;
    base    = grantLog.size();
    applyStimulus(0, 1'b1, 1'b1, 64'h8000, 64'h1234, 8'hF0);
    waitGrants(base + 1, 20);
    setReq(0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 64'h9000, 64'h0, 8'hFF);
    waitRvalid(20);
    checkOutput("err_s_rvalid", 64'(s_rvalid), 64'h1);
    checkOutput("err_s_err", 64'(s_err), 64'd1);
    checkOutput("err_next_gnt", 64'(s_gnt), 64'h2);
    @(posedge aclk); #1;
    setReq(1, 1'b0);
    rspErr = 1'b0;
    waitIdle(20);

    repeat (3) @(posedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_sba_bus_arbiter.md
Name: dm_sba_bus_arbiter

Overview:
- Round-robin arbiter sharing one system-bus request port between NUM_REQ requesters.
- Requester 0 is the debug module system-bus-access master; the others are, for example, a boot loader or trace DMA.
- Only one transaction is outstanding at a time. The owner is locked from grant until its response returns.
- Sits between the debug module wrapper and the AXI bridge in the FPGA block design.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, data width; byte-enable width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, response watchdog limit; used only with DM_ARB_TIMEOUT_EN.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_req  in  NUM_REQ  per-requester request.
- s_we  in  NUM_REQ  per-requester write enable.
- s_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address; requester i in slice i.
- s_wdata  in  NUM_REQ*DATA_WIDTH  per-requester write data.
- s_be  in  NUM_REQ*DATA_WIDTH/8  per-requester byte enables.
- s_gnt  out  NUM_REQ  one-cycle grant pulse, one-hot.
- s_rvalid  out  NUM_REQ  one-cycle response pulse, one-hot.
- s_rdata  out  DATA_WIDTH  response data, broadcast to all requesters.
- s_err  out  1  response error, valid with s_rvalid.
- m_req  out  1  downstream request.
- m_we  out  1  downstream write enable.
- m_addr  out  ADDR_WIDTH  downstream address.
- m_wdata  out  DATA_WIDTH  downstream write data.
- m_be  out  DATA_WIDTH/8  downstream byte enables.
- m_gnt  in  1  downstream accept.
- m_rvalid  in  1  downstream response valid (reads and writes).
- m_rdata  in  DATA_WIDTH  downstream response data.
- m_err  in  1  downstream error.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: one clock aclk; reset aresetn is asynchronous, active-low.
- Reset values:
  - state = IDLE; rr_ptr = NUM_REQ-1, so requester 0 wins first.
  - s_gnt, s_rvalid, m_req, busy = 0; s_err = 0.
  - Held request registers and s_rdata = 0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any s_req bit is set, select the first set index searching upward from rr_ptr+1, wrapping mod NUM_REQ.
  - In that cycle: pulse s_gnt[sel] and capture we/addr/wdata/be of sel into held registers. Store owner = sel, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - m_req = 1, driven only from held registers, so requester input changes have no effect.
  - Hold until m_gnt = 1, then go to WAIT.
  - m_rvalid while in ISSUE is ignored (downstream protocol violation).
- WAIT:
  - m_req = 0.
  - On m_rvalid: register m_rdata into s_rdata and m_err into s_err, and pulse s_rvalid[owner] the next cycle.
  - Also set rr_ptr = owner and go to IDLE.
  - s_rdata and s_err hold until the next response.
- Latency:
  - s_req to s_gnt: 0 cycles, combinational in IDLE.
  - s_gnt to m_req: 1 cycle.
  - m_rvalid to s_rvalid: 1 cycle.
  - Back-to-back: a new grant is possible in the cycle s_rvalid pulses. Peak rate is one transaction per 3 cycles plus downstream latency.
- Requester handshake:
  - Hold s_req and its fields stable until s_gnt; s_req may drop after s_gnt.
  - Dropping s_req before s_gnt withdraws the request legally.
  - A requester that re-asserts s_req while a transaction is outstanding waits; it is arbitrated in the next IDLE.
- Fairness: with all NUM_REQ requesters continuously requesting, grants rotate strictly 0,1,...,NUM_REQ-1,0,...
- Asynchronous reset mid-transaction: return immediately to IDLE and drop m_req. No s_rvalid is produced for the aborted owner, and a later stale m_rvalid is ignored in IDLE.
- m_rvalid in IDLE is ignored.

Optional Feature:
- Macro: DM_ARB_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no m_rvalid, pulse s_rvalid[owner] with s_err = 1 and s_rdata = 0. Advance rr_ptr and go to IDLE.
  - The counter does not run in ISSUE.
  - If m_rvalid arrives in the same cycle the limit is reached, the real response wins.
- Disabled: no counter; WAIT lasts until m_rvalid.

Test Plan:
- Reset, then s_req = 2'b11 held with addr0 = 0x1000 and addr1 = 0x2000, m_gnt = 1, m_rvalid two cycles after m_gnt -> first m_addr = 0x1000, second m_addr = 0x2000, and s_gnt pulses alternate 01, 10, 01.
- Requester 1 read of 0x80000000 with m_rdata = 0xDEADBEEF_CAFEF00D, m_err = 0 -> s_rvalid = 2'b10 one cycle after m_rvalid, with s_rdata equal to that value and s_err = 0.
- m_gnt held low for 5 cycles in ISSUE while requester 0 changes s_addr -> m_req stays high and m_addr stays at the captured value for all 5 cycles.
- aresetn asserted in WAIT -> m_req, busy and s_rvalid = 0 immediately. A stale m_rvalid after reset release gives no s_rvalid, and the next s_req from requester 0 is granted first.
- With DM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16: no m_rvalid -> s_rvalid[owner] with s_err = 1 and s_rdata = 0 after 16 WAIT cycles, then busy = 0. With the macro off, busy stays high for at least 100 cycles.
- m_err = 1 on a write response from requester 0 -> s_err = 1 with s_rvalid = 2'b01, and the next grant goes to requester 1 if it is requesting.
